// File: rtl/ro_puf_array.sv
// Ring-oscillator PUF: N_RO gated rings, one saturating edge counter per ring,
// and a controller that races ring pairs for a fixed window and packs one
// response bit per pair.
//
// Each ring is a NAND enable gate plus STAGES inverters. Every gate in the ring
// is modelled as one propagation step. A step fires when the ring's prescaler
// reaches terminal count. RING_DLY[8*i +: 8] sets ring i's gate delay in clk
// ticks minus one, and stands in for process variation.
// An odd STAGES plus the NAND would give an even inversion count. To keep the
// loop oscillating, the NAND feedback pin takes the complement of the last
// stage.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; selections captured on accept
// CLEAR    | ring counters held in async clear for one cycle
// RUN      | rings enabled for WINDOW cycles
// SETTLE   | rings disabled; counters go quiet for SETTLE cycles
// CAPTURE  | sample counters of current pair into cnt_a / cnt_b
// COMPARE  | response[k] <= cnt_a > cnt_b; advance pair or finish
// DONE     | one-cycle done pulse, busy already low
module ro_puf_array #(
  parameter int N_RO      = 8,
  parameter int STAGES    = 9,
  parameter int CNT_W     = 16,
  parameter int WINDOW    = 1024,
  parameter int SETTLE    = 4,
  parameter int RESP_BITS = 8,
  parameter logic [8*N_RO-1:0] RING_DLY = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [$clog2(N_RO)-1:0] sel_a,
  input  logic [$clog2(N_RO)-1:0] sel_b,
  output logic                    busy,
  output logic                    done,
  output logic [RESP_BITS-1:0]    response,
  output logic [CNT_W-1:0]        cnt_a,
  output logic [CNT_W-1:0]        cnt_b
);

  localparam int AW   = $clog2(N_RO);
  localparam int KW   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  // Static pattern of a disabled ring: NAND output high, inverters alternate.
  function automatic logic [STAGES-1:0] rest_pattern();
    logic [STAGES-1:0] r;
    for (int j = 0; j < STAGES; j++) r[j] = j[0];
    return r;
  endfunction

  localparam logic [STAGES-1:0] REST = rest_pattern();

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_CAPTURE, S_COMPARE, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic              en_q;
  logic              clr_q;
  logic              clr_n;
  logic [TW-1:0]     tmr;
  logic [KW-1:0]     k;
  logic [AW-1:0]     a_idx, b_idx;
  wire  [N_RO-1:0]   ro_nand;
  logic [CNT_W-1:0]  ro_cnt [N_RO];

  // Clear comes from a register so the async clear pin never sees decode glitches.
  assign clr_n = rst_n & ~clr_q;

  for (genvar i = 0; i < N_RO; i++) begin : g_ring
    logic [STAGES-1:0] stg;
    logic [7:0]        presc;
    logic [CNT_W-1:0]  cnt;

    assign ro_nand[i] = ~(en_q & ~stg[STAGES-1]);
    assign ro_cnt[i]  = cnt;

    // One gate-propagation step each time the delay prescaler reaches zero.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stg   <= REST;
        presc <= '0;
      end else if (presc == 8'd0) begin
        presc <= RING_DLY[8*i +: 8];
        stg   <= ~{stg[STAGES-2:0], ro_nand[i]};
      end else begin
        presc <= presc - 8'd1;
      end
    end

    // Saturating edge counter in the ring's own clock domain.
    always_ff @(posedge ro_nand[i] or negedge clr_n) begin
      if (!clr_n)            cnt <= '0;
      else if (cnt != '1)    cnt <= cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE) && (state != S_DONE);
    done      = (state == S_DONE);
    case (state)
      S_IDLE:    if (start) state_nxt = S_CLEAR;
      S_CLEAR:   state_nxt = S_RUN;
      S_RUN:     if (tmr == '0) state_nxt = S_SETTLE;
      S_SETTLE:  if (tmr == '0) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_COMPARE;
      S_COMPARE: state_nxt = (k == KW'(RESP_BITS-1)) ? S_DONE : S_CLEAR;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Window timer, pair indices, ring enable/clear, sampled counts and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      clr_q    <= 1'b0;
      tmr      <= '0;
      k        <= '0;
      a_idx    <= '0;
      b_idx    <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      response <= '0;
    end else begin
      en_q  <= (state_nxt == S_RUN);
      clr_q <= (state_nxt == S_CLEAR);
      case (state)
        S_IDLE: if (start) begin
          a_idx    <= sel_a;
          b_idx    <= sel_b;
          k        <= '0;
          response <= '0;
        end
        S_CLEAR: tmr <= TW'(WINDOW - 1);
        S_RUN:   tmr <= (tmr == '0) ? TW'(SETTLE - 1) : tmr - 1'b1;
        S_SETTLE: if (tmr != '0) tmr <= tmr - 1'b1;
        S_CAPTURE: begin
          cnt_a <= ro_cnt[a_idx];
          cnt_b <= ro_cnt[b_idx];
        end
        S_COMPARE: begin
          response[k] <= (cnt_a > cnt_b);
          if (k != KW'(RESP_BITS-1)) begin
            k     <= k + 1'b1;
            a_idx <= (a_idx == AW'(N_RO-1)) ? '0 : a_idx + 1'b1;
            b_idx <= (b_idx == AW'(N_RO-1)) ? '0 : b_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_array.sv
// Bench for ro_puf_array: three instances with different ring speeds, widths
// and response lengths; expected responses queued at start, checked at done.
module tb_ro_puf_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] start_v;
  logic [1:0] sa [3];
  logic [1:0] sb [3];

  wire  [2:0]  busy_v, done_v;
  wire  [3:0]  resp0;
  wire  [0:0]  resp1, resp2;
  wire  [15:0] ca0, cb0, ca1, cb1;
  wire  [3:0]  ca2, cb2;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q [$];

  // Spec latency counts the start cycle and the done cycle; edges between them are one fewer.
  localparam int LAT0 = 2 + 4 * (1 + 64 + 4 + 2);
  localparam int LAT1 = 2 + 1 * (1 + 64 + 4 + 2);
  localparam int LAT2 = 2 + 1 * (1 + 1000 + 4 + 2);

  // Ring 0 fast, rings 1..3 slow.
  ro_puf_array #(.N_RO(4), .STAGES(3), .CNT_W(16), .WINDOW(64), .SETTLE(4),
                 .RESP_BITS(4), .RING_DLY(32'h01_01_01_00)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sel_a(sa[0]), .sel_b(sb[0]),
    .busy(busy_v[0]), .done(done_v[0]), .response(resp0), .cnt_a(ca0), .cnt_b(cb0));

  // Ring 2 fast, others slow.
  ro_puf_array #(.N_RO(4), .STAGES(3), .CNT_W(16), .WINDOW(64), .SETTLE(4),
                 .RESP_BITS(1), .RING_DLY(32'h01_00_01_01)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sel_a(sa[1]), .sel_b(sb[1]),
    .busy(busy_v[1]), .done(done_v[1]), .response(resp1), .cnt_a(ca1), .cnt_b(cb1));

  // Narrow counters, long window: everything saturates.
  ro_puf_array #(.N_RO(4), .STAGES(9), .CNT_W(4), .WINDOW(1000), .SETTLE(4),
                 .RESP_BITS(1), .RING_DLY(32'h0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sel_a(sa[2]), .sel_b(sb[2]),
    .busy(busy_v[2]), .done(done_v[2]), .response(resp2), .cnt_a(ca2), .cnt_b(cb2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] resp_of(input int id);
    case (id)
      0: return {28'd0, resp0};
      1: return {31'd0, resp1};
      default: return {31'd0, resp2};
    endcase
  endfunction

  function automatic logic [31:0] cnta_of(input int id);
    case (id)
      0: return {16'd0, ca0};
      1: return {16'd0, ca1};
      default: return {28'd0, ca2};
    endcase
  endfunction

  function automatic logic [31:0] cntb_of(input int id);
    case (id)
      0: return {16'd0, cb0};
      1: return {16'd0, cb1};
      default: return {28'd0, cb2};
    endcase
  endfunction

  // mode: 0 no count check, 1 equal and nonzero, 2 both saturated at 15.
  task automatic run(input int id, input logic [1:0] a, input logic [1:0] b,
                     input logic [3:0] exp, input int lat, input int mode, input bit guard);
    int n;
    int extra;
    bit got;
    logic [3:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    sa[id] = a;
    sb[id] = b;
    start_v[id] = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        start_v[id] = 1'b0;
        check($sformatf("busy_after_start%0d", id), {31'd0, busy_v[id]}, 32'd1);
      end
      if (n == 2) begin
        sa[id] = a + 2'd1;
        sb[id] = b + 2'd2;
      end
      if (guard && n == 10) start_v[id] = 1'b1;
      if (guard && n == 11) start_v[id] = 1'b0;
      if (done_v[id]) got = 1'b1;
    end
    e = exp_q.pop_front();
    check($sformatf("latency%0d", id), n, lat - 1);
    check($sformatf("response%0d", id), resp_of(id), {28'd0, e});
    check($sformatf("busy_at_done%0d", id), {31'd0, busy_v[id]}, 32'd0);
    if (mode == 1) begin
      check($sformatf("cnt_equal%0d", id), cnta_of(id), cntb_of(id));
      check($sformatf("cnt_nonzero%0d", id), {31'd0, cnta_of(id) > 0}, 32'd1);
    end else if (mode == 2) begin
      check($sformatf("cnt_a_sat%0d", id), cnta_of(id), 32'd15);
      check($sformatf("cnt_b_sat%0d", id), cntb_of(id), 32'd15);
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_v[id]) extra++;
    end
    check($sformatf("single_done%0d", id), extra, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_v = '0;
    for (int i = 0; i < 3; i++) begin
      sa[i] = '0;
      sb[i] = '0;
    end
    #23;
    check("rst_busy", {29'd0, busy_v}, 32'd0);
    check("rst_done", {29'd0, done_v}, 32'd0);
    check("rst_resp0", resp_of(0), 32'd0);
    check("rst_cnt_a0", cnta_of(0), 32'd0);
    check("rst_cnt_b0", cntb_of(0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Same ring on both sides: every compare ties.
    run(0, 2'd1, 2'd1, 4'b0000, LAT0, 1, 1'b0);
    // Pairs (0,1),(1,2),(2,3),(3,0); only ring 0 is fast.
    run(0, 2'd0, 2'd1, 4'b0001, LAT0, 0, 1'b0);
    // Second start 10 cycles in is ignored.
    run(0, 2'd0, 2'd1, 4'b0001, LAT0, 0, 1'b1);

    // Reset in the middle of RUN.
    @(negedge clk);
    sa[0] = 2'd0;
    sb[0] = 2'd1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_mid_run", {31'd0, busy_v[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy_v[0]}, 32'd0);
    check("mid_rst_done", {31'd0, done_v[0]}, 32'd0);
    check("mid_rst_resp", resp_of(0), 32'd0);
    check("mid_rst_cnt_a", cnta_of(0), 32'd0);
    check("mid_rst_cnt_b", cntb_of(0), 32'd0);
    check("mid_rst_rings_static", {28'd0, dut0.ro_nand}, 32'hf);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run(0, 2'd1, 2'd1, 4'b0000, LAT0, 1, 1'b0);

    // Ring 2 faster than ring 3, then swapped.
    run(1, 2'd2, 2'd3, 4'b0001, LAT1, 0, 1'b0);
    run(1, 2'd3, 2'd2, 4'b0000, LAT1, 0, 1'b0);

    // Saturation: both counters pinned at 15, tie gives 0.
    run(2, 2'd0, 2'd1, 4'b0000, LAT2, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
